mc_proc_controller: RTL and testbench

MC_PROC_CONTROLLER -- requirements
Module: mc_proc_controller

---
 rtl/mc_ctrl_pkg.sv | 46 ++++
 rtl/mc_wait_timer.sv | 30 +++
 rtl/mc_proc_controller.sv | 156 +++++++++++++++
 tb/tb_mc_proc_controller.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle processor controller: opcodes, states,
// write-back selects and trap causes.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  localparam logic [3:0] OP_ALUR  = 4'b0000;
  localparam logic [3:0] OP_ALUI  = 4'b1000;
  localparam logic [3:0] OP_CMPR  = 4'b0010;
  localparam logic [3:0] OP_CMPI  = 4'b1010;
  localparam logic [3:0] OP_BCOND = 4'b0110;
  localparam logic [3:0] OP_JAL   = 4'b0101;
  localparam logic [3:0] OP_LW    = 4'b1001;
  localparam logic [3:0] OP_SW    = 4'b1011;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] TC_NONE    = 2'd0;
  localparam logic [1:0] TC_ILLEGAL = 2'd1;
  localparam logic [1:0] TC_TIMEOUT = 2'd2;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_ALUR, OP_ALUI, OP_CMPR, OP_CMPI,
      OP_BCOND, OP_JAL, OP_LW, OP_SW: op_legal = 1'b1;
      default:                        op_legal = 1'b0;
    endcase
  endfunction

  function automatic logic op_uses_imm(input logic [3:0] op);
    case (op)
      OP_ALUI, OP_CMPI, OP_LW, OP_SW, OP_JAL: op_uses_imm = 1'b1;
      default:                                op_uses_imm = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Counts consecutive stalled cycles of an outstanding bus request and flags
// expiry on the cycle the count would reach WAIT_LIMIT.
module mc_wait_timer #(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic busy,
  input  logic ready,
  output logic expired
);

  logic [7:0] cnt_q, cnt_d, base;

  // start marks the first cycle of a new request, so stale counts never carry over
  assign base    = start ? 8'd0 : cnt_q;
  assign expired = busy && !ready && (base == 8'(WAIT_LIMIT - 1));

  always_comb begin
    cnt_d = 8'd0;
    if (busy && !ready) cnt_d = base + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= 8'd0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mc_proc_controller.sv
// Multi-cycle processor control FSM with bus timeout trap.
// Optional performance counters enabled by defining MC_CTRL_PERF_CNT_EN.
module mc_proc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned OP_BIT_WIDTH = 4,
  parameter int unsigned CNT_BITS     = 32,
  parameter int unsigned WAIT_LIMIT   = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [OP_BIT_WIDTH-1:0] op1,
  input  logic                    cond_true,
  input  logic                    imem_ready,
  input  logic                    dmem_ready,
  output logic                    imem_req,
  output logic                    dmem_req,
  output logic                    dmem_we,
  output logic                    ir_wr_en,
  output logic                    pc_wr_en,
  output logic                    pc_sel,
  output logic                    reg_wr_en,
  output logic [1:0]              wb_sel,
  output logic                    alu_src_imm,
  output logic [2:0]              state_o,
  output logic                    trap,
  output logic [1:0]              trap_cause,
  output logic [CNT_BITS-1:0]     instret,
  output logic [CNT_BITS-1:0]     cycles
);

  state_e     state_q, state_d;
  logic [1:0] cause_q, cause_d;
  logic       start_q;
  logic [3:0] op;
  logic       legal, busy, rdy, expired;

  // opcode bits above the 4-bit encoding space must be zero to be legal
  assign op    = op1[3:0];
  assign legal = op_legal(op) && ((op1 >> 4) == '0);
  assign busy  = (state_q == S_FETCH) || (state_q == S_MEM);
  assign rdy   = (state_q == S_FETCH) ? imem_ready : dmem_ready;

  mc_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .start   (start_q),
    .busy    (busy),
    .ready   (rdy),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cause_q <= TC_NONE;
      start_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      start_q <= (state_d != state_q);
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      S_FETCH:
        if (imem_ready) state_d = S_DECODE;
        else if (expired) begin state_d = S_TRAP; cause_d = TC_TIMEOUT; end
      S_DECODE:
        if (legal) state_d = S_EXEC;
        else begin state_d = S_TRAP; cause_d = TC_ILLEGAL; end
      S_EXEC:
        case (op)
          OP_BCOND:     state_d = S_FETCH;
          OP_LW, OP_SW: state_d = S_MEM;
          default:      state_d = S_WB;
        endcase
      S_MEM:
        if (dmem_ready) state_d = (op == OP_SW) ? S_FETCH : S_WB;
        else if (expired) begin state_d = S_TRAP; cause_d = TC_TIMEOUT; end
      S_WB:    state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // outputs are gated by reset so nothing strobes while reset is held
  always_comb begin
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    ir_wr_en    = 1'b0;
    pc_wr_en    = 1'b0;
    pc_sel      = 1'b0;
    reg_wr_en   = 1'b0;
    wb_sel      = WB_ALU;
    alu_src_imm = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_wr_en = imem_ready;
          pc_wr_en = imem_ready;
        end
        S_EXEC: begin
          alu_src_imm = op_uses_imm(op);
          if (op == OP_BCOND && cond_true) begin
            pc_wr_en = 1'b1;
            pc_sel   = 1'b1;
          end
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (op == OP_SW);
        end
        S_WB: begin
          reg_wr_en = 1'b1;
          wb_sel    = (op == OP_LW) ? WB_MEM : (op == OP_JAL) ? WB_PC4 : WB_ALU;
          if (op == OP_JAL) begin
            pc_wr_en = 1'b1;
            pc_sel   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign state_o    = state_q;
  assign trap       = (state_q == S_TRAP);
  assign trap_cause = cause_q;

`ifdef MC_CTRL_PERF_CNT_EN
  logic [CNT_BITS-1:0] cycles_q, instret_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycles_q  <= '0;
      instret_q <= '0;
    end else if (state_q != S_TRAP) begin
      cycles_q <= cycles_q + CNT_BITS'(1);
      if (state_d == S_FETCH && state_q != S_FETCH) instret_q <= instret_q + CNT_BITS'(1);
    end
  end

  assign cycles  = cycles_q;
  assign instret = instret_q;
`else
  assign cycles  = '0;
  assign instret = '0;
`endif

endmodule

// File: tb/tb_mc_proc_controller.sv
// Scoreboard bench: stimulus pushes hand-derived per-cycle expectations,
// a negedge monitor pops and compares them against the controller outputs.
module tb_mc_proc_controller;
  import mc_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  op1;
  logic        cond_true, imem_ready, dmem_ready;
  logic        imem_req, dmem_req, dmem_we, ir_wr_en, pc_wr_en, pc_sel, reg_wr_en;
  logic [1:0]  wb_sel;
  logic        alu_src_imm;
  logic [2:0]  state_o;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [31:0] instret, cycles;

  mc_proc_controller dut (
    .clk(clk), .reset(reset), .op1(op1), .cond_true(cond_true),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .ir_wr_en(ir_wr_en), .pc_wr_en(pc_wr_en), .pc_sel(pc_sel),
    .reg_wr_en(reg_wr_en), .wb_sel(wb_sel), .alu_src_imm(alu_src_imm),
    .state_o(state_o), .trap(trap), .trap_cause(trap_cause),
    .instret(instret), .cycles(cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  st;
    logic        ireq, dreq, we, ir, pcw, pcs, rw;
    logic [1:0]  wbs;
    logic        imm, trp;
    logic [1:0]  cause;
    logic        chk;
    logic [31:0] ins, cyc;
    int          id;
  } exp_t;

  exp_t expq[$];
  exp_t m;
  int   checks = 0, failures = 0, step = 0;
  logic chk_pend = 1'b0;
  logic [31:0] ins_pend, cyc_pend;

  function automatic exp_t mk(logic [2:0] st, logic ireq, logic dreq, logic we, logic ir,
                              logic pcw, logic pcs, logic rw, logic [1:0] wbs, logic imm,
                              logic trp, logic [1:0] cause);
    exp_t e;
    e.st = st; e.ireq = ireq; e.dreq = dreq; e.we = we; e.ir = ir; e.pcw = pcw;
    e.pcs = pcs; e.rw = rw; e.wbs = wbs; e.imm = imm; e.trp = trp; e.cause = cause;
    e.chk = 1'b0; e.ins = '0; e.cyc = '0; e.id = 0;
    return e;
  endfunction

  function automatic exp_t eR();                return mk(S_FETCH, 0,0,0,0,0,0,0,2'd0,0,0,2'd0); endfunction
  function automatic exp_t eF(logic r);         return mk(S_FETCH, 1,0,0,r,r,0,0,2'd0,0,0,2'd0); endfunction
  function automatic exp_t eD();                return mk(S_DECODE,0,0,0,0,0,0,0,2'd0,0,0,2'd0); endfunction
  function automatic exp_t eE(logic i, logic b); return mk(S_EXEC, 0,0,0,0,b,1,0,2'd0,i,0,2'd0); endfunction
  function automatic exp_t eM(logic w);         return mk(S_MEM,   0,1,w,0,0,0,0,2'd0,0,0,2'd0); endfunction
  function automatic exp_t eW(logic [1:0] s, logic j); return mk(S_WB, 0,0,0,0,j,1,1,s,0,0,2'd0); endfunction
  function automatic exp_t eT(logic [1:0] c);   return mk(S_TRAP,  0,0,0,0,0,0,0,2'd0,0,1,c); endfunction

  task automatic expect_cnt(input int i, input int c);
    chk_pend = 1'b1;
`ifdef MC_CTRL_PERF_CNT_EN
    ins_pend = i; cyc_pend = c;
`else
    ins_pend = 0; cyc_pend = 0;
    if (i < 0 || c < 0) chk_pend = 1'b1;
`endif
  endtask

  task automatic cyc(input logic ir_r, input logic dr_r, input logic ct, input exp_t e);
    imem_ready = ir_r; dmem_ready = dr_r; cond_true = ct;
    e.id = step; step++;
    if (chk_pend) begin e.chk = 1'b1; e.ins = ins_pend; e.cyc = cyc_pend; chk_pend = 1'b0; end
    expq.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic run_op(input logic [3:0] op, input logic ct, input int iw, input int dw);
    logic imm, mem;
    imm = (op == OP_ALUI) || (op == OP_CMPI) || (op == OP_LW) || (op == OP_SW) || (op == OP_JAL);
    mem = (op == OP_LW) || (op == OP_SW);
    op1 = op;
    repeat (iw) cyc(0, 0, 0, eF(0));
    cyc(1, 0, 0, eF(1));
    cyc(0, 0, 0, eD());
    cyc(0, 0, ct, eE(imm, (op == OP_BCOND) && ct));
    if (mem) begin
      repeat (dw) cyc(0, 0, 0, eM(op == OP_SW));
      cyc(0, 1, 0, eM(op == OP_SW));
    end
    if (op != OP_BCOND && op != OP_SW)
      cyc(0, 0, 0, eW((op == OP_LW) ? 2'd1 : (op == OP_JAL) ? 2'd2 : 2'd0, op == OP_JAL));
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      m = expq.pop_front();
      checks++;
      if (!(state_o === m.st && imem_req === m.ireq && dmem_req === m.dreq && dmem_we === m.we &&
            ir_wr_en === m.ir && pc_wr_en === m.pcw && reg_wr_en === m.rw && trap === m.trp &&
            trap_cause === m.cause && (!m.pcw || pc_sel === m.pcs) && (!m.rw || wb_sel === m.wbs) &&
            (m.st != S_EXEC || alu_src_imm === m.imm))) begin
        failures++;
        $display("FAIL step%0d outs got st=%0d ireq=%b dreq=%b we=%b ir=%b pcw=%b pcs=%b rw=%b wbs=%0d imm=%b trap=%b cause=%0d exp st=%0d ireq=%b dreq=%b we=%b ir=%b pcw=%b pcs=%b rw=%b wbs=%0d imm=%b trap=%b cause=%0d",
                 m.id, state_o, imem_req, dmem_req, dmem_we, ir_wr_en, pc_wr_en, pc_sel, reg_wr_en,
                 wb_sel, alu_src_imm, trap, trap_cause, m.st, m.ireq, m.dreq, m.we, m.ir, m.pcw,
                 m.pcs, m.rw, m.wbs, m.imm, m.trp, m.cause);
      end
      if (m.chk) begin
        checks++;
        if (instret !== m.ins || cycles !== m.cyc) begin
          failures++;
          $display("FAIL step%0d counters got instret=%0d cycles=%0d exp instret=%0d cycles=%0d",
                   m.id, instret, cycles, m.ins, m.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, got timeout exp finish");
    $fatal(1);
  end

  initial begin
    op1 = OP_ALUR; cond_true = 0; imem_ready = 0; dmem_ready = 0; reset = 1'b1;
    @(posedge clk); #1;
    // inputs high while reset is held: no strobes may leak out
    expect_cnt(0, 0);
    repeat (3) cyc(1, 1, 1, eR());
    reset = 1'b0;

    run_op(OP_ALUR, 0, 0, 0);
    expect_cnt(1, 4);
    run_op(OP_ALUI, 0, 0, 0);
    run_op(OP_LW, 0, 0, 3);
    run_op(OP_BCOND, 0, 0, 0);
    run_op(OP_BCOND, 1, 0, 0);
    run_op(OP_JAL, 0, 0, 0);
    run_op(OP_SW, 0, 0, 0);
    run_op(OP_CMPI, 0, 0, 0);
    run_op(OP_CMPR, 0, 0, 0);
    run_op(OP_ALUR, 0, 14, 0);   // ready arrives on the 15th fetch cycle: no trap

    // illegal opcode, then trap must hold everything low
    op1 = 4'b0111;
    expect_cnt(10, 56);
    cyc(1, 0, 0, eF(1));
    cyc(0, 0, 0, eD());
    expect_cnt(10, 58);
    cyc(1, 1, 1, eT(TC_ILLEGAL));
    repeat (18) cyc(1, 1, 1, eT(TC_ILLEGAL));
    expect_cnt(10, 58);
    cyc(1, 1, 1, eT(TC_ILLEGAL));

    reset = 1'b1;
    expect_cnt(0, 0);
    repeat (2) cyc(1, 1, 1, eR());
    reset = 1'b0;

    // fetch timeout after 15 stalled cycles
    op1 = OP_ALUR;
    repeat (15) cyc(0, 0, 0, eF(0));
    expect_cnt(0, 15);
    repeat (3) cyc(1, 1, 1, eT(TC_TIMEOUT));

    reset = 1'b1;
    cyc(0, 0, 0, eR());
    reset = 1'b0;

    // reset during SW memory phase aborts the store
    op1 = OP_SW;
    cyc(1, 0, 0, eF(1));
    cyc(0, 0, 0, eD());
    cyc(0, 0, 0, eE(1, 0));
    repeat (2) cyc(0, 0, 0, eM(1));
    reset = 1'b1;
    expect_cnt(0, 0);
    cyc(0, 1, 0, eR());
    reset = 1'b0;
    expect_cnt(0, 0);
    cyc(0, 0, 0, eF(0));

    // data-side timeout on LW
    op1 = OP_LW;
    cyc(1, 0, 0, eF(1));
    cyc(0, 0, 0, eD());
    cyc(0, 0, 0, eE(1, 0));
    repeat (15) cyc(0, 0, 0, eM(0));
    repeat (2) cyc(1, 1, 1, eT(TC_TIMEOUT));

    repeat (2) @(posedge clk);
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL drain queue got %0d pending exp 0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
